// File: rtl/mips_muldiv_pkg.sv
// mips_muldiv_pkg: shared op/state encodings and default width for the multiply/divide unit
package mips_muldiv_pkg;
  localparam int DEF_WIDTH = 32;
  typedef enum logic [1:0] {OP_MULTU = 2'b00, OP_MULT = 2'b01, OP_DIVU = 2'b10, OP_DIV = 2'b11} op_e;
  typedef enum logic [1:0] {ST_IDLE = 2'b00, ST_RUN = 2'b01, ST_FIX = 2'b10} state_e;
endpackage

// File: rtl/mips_muldiv_if.sv
// mips_muldiv_if: request/result bundle between control FSM (master) and the mul/div unit (slave)
interface mips_muldiv_if import mips_muldiv_pkg::*; #(parameter int WIDTH = DEF_WIDTH);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             cancel;
  logic             wr_hi;
  logic             wr_lo;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  modport master (output start, op, src_a, src_b, cancel, wr_hi, wr_lo, wdata,
                  input  hi, lo, busy, done);
  modport slave  (input  start, op, src_a, src_b, cancel, wr_hi, wr_lo, wdata,
                  output hi, lo, busy, done);
endinterface

// File: rtl/mips_muldiv_step.sv
// mips_muldiv_step: one iteration of shift-add multiply or restoring divide on the {hi,lo} accumulator
module mips_muldiv_step #(parameter int WIDTH = 32) (
  input  logic             div_i,
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] lo_i,
  input  logic [WIDTH-1:0] opnd_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);
  logic [WIDTH:0] sum;
  logic [WIDTH:0] shl;
  logic [WIDTH:0] diff;
  // mul: conditional add then shift right; div: shift left, trial subtract, quotient bit = no borrow
  always_comb begin
    sum  = {1'b0, hi_i} + (lo_i[0] ? {1'b0, opnd_i} : '0);
    shl  = {hi_i, lo_i[WIDTH-1]};
    diff = shl - {1'b0, opnd_i};
    hi_o = div_i ? (diff[WIDTH] ? shl[WIDTH-1:0] : diff[WIDTH-1:0]) : sum[WIDTH:1];
    lo_o = div_i ? {lo_i[WIDTH-2:0], ~diff[WIDTH]} : {sum[0], lo_i[WIDTH-1:1]};
  end
endmodule

// File: rtl/mips_muldiv.sv
// mips_muldiv: iterative MULT/MULTU/DIV/DIVU unit holding HI/LO; signed ops enabled by MULDIV_SIGNED_EN
module mips_muldiv import mips_muldiv_pkg::*; #(parameter int WIDTH = DEF_WIDTH) (
  input logic clk,
  input logic rst,
  mips_muldiv_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic             div_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] opnd_q;
  logic [WIDTH-1:0] acc_hi_q;
  logic [WIDTH-1:0] acc_lo_q;
  logic [WIDTH-1:0] acc_hi_d;
  logic [WIDTH-1:0] acc_lo_d;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  op_e              op_in;
  logic             div_in;
  assign op_in  = op_e'(bus.op);
  assign div_in = (op_in == OP_DIVU) || (op_in == OP_DIV);
`ifdef MULDIV_SIGNED_EN
  logic neg_p_q;
  logic neg_r_q;
  logic sa;
  logic sb;
  assign sa    = ((op_in == OP_MULT) || (op_in == OP_DIV)) && bus.src_a[WIDTH-1];
  assign sb    = ((op_in == OP_MULT) || (op_in == OP_DIV)) && bus.src_b[WIDTH-1];
  assign a_mag = sa ? -bus.src_a : bus.src_a;
  assign b_mag = sb ? -bus.src_b : bus.src_b;
`else
  assign a_mag = bus.src_a;
  assign b_mag = bus.src_b;
`endif
  mips_muldiv_step #(.WIDTH(WIDTH)) u_step (
    .div_i (div_q),
    .hi_i  (acc_hi_q),
    .lo_i  (acc_lo_q),
    .opnd_i(opnd_q),
    .hi_o  (acc_hi_d),
    .lo_o  (acc_lo_d)
  );
  // control FSM: accept op or HI/LO write in IDLE, iterate in RUN, commit result in FIX
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.start && !bus.cancel) begin
            state_q  <= ST_RUN;
            busy_q   <= 1'b1;
            cnt_q    <= CW'(WIDTH - 1);
            div_q    <= div_in;
            opnd_q   <= div_in ? b_mag : a_mag;
            acc_hi_q <= '0;
            acc_lo_q <= div_in ? a_mag : b_mag;
`ifdef MULDIV_SIGNED_EN
            neg_p_q  <= (sa ^ sb) && !(div_in && bus.src_b == '0);
            neg_r_q  <= sa;
`endif
          end else if (!bus.start) begin
            if (bus.wr_hi) hi_q <= bus.wdata;
            if (bus.wr_lo) lo_q <= bus.wdata;
          end
        end
        ST_RUN: begin
          if (bus.cancel) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            cnt_q    <= cnt_q - 1'b1;
            if (cnt_q == '0) state_q <= ST_FIX;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          if (!bus.cancel) begin
            done_q <= 1'b1;
`ifdef MULDIV_SIGNED_EN
            if (div_q) begin
              lo_q <= neg_p_q ? -acc_lo_q : acc_lo_q;
              hi_q <= neg_r_q ? -acc_hi_q : acc_hi_q;
            end else begin
              {hi_q, lo_q} <= neg_p_q ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};
            end
`else
            hi_q <= acc_hi_q;
            lo_q <= acc_lo_q;
`endif
          end
        end
      endcase
    end
  end
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
endmodule

// File: tb/tb_mips_muldiv.sv
// tb_mips_muldiv: randomized and directed checks of mips_muldiv against an arithmetic reference model
module tb_mips_muldiv;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int passed = 0;
  mips_muldiv_if #(.WIDTH(32)) bus();
  mips_muldiv #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic sgn;
    longint sa, sb;
    sgn = 1'b0;
`ifdef MULDIV_SIGNED_EN
    sgn = op[0];
`endif
    sa = sgn ? longint'($signed(a)) : longint'({32'b0, a});
    sb = sgn ? longint'($signed(b)) : longint'({32'b0, b});
    if (!op[1]) return 64'(sa * sb);
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
    return {32'(sa % sb), 32'(sa / sb)};
  endfunction

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, output int lat);
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.src_a = a; bus.src_b = b;
    @(posedge clk); #1 bus.start = 1'b0;
    lat = 0;
    while (lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (bus.done) break;
    end
  endtask

  task automatic write_hl(input logic h, input logic l, input logic [31:0] d);
    @(negedge clk);
    bus.wr_hi = h; bus.wr_lo = l; bus.wdata = d;
    @(negedge clk);
    bus.wr_hi = 1'b0; bus.wr_lo = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.hi !== 32'd0) $display("FAIL reset_hi: got %h want 0", bus.hi); else passed++;
    checks++; if (bus.lo !== 32'd0) $display("FAIL reset_lo: got %h want 0", bus.lo); else passed++;
    checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else passed++;
    checks++; if (bus.done !== 1'b0) $display("FAIL reset_done: got %b want 0", bus.done); else passed++;
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_mthi_mtlo();
    write_hl(1'b1, 1'b1, 32'hA5A5_0001);
    checks++; if (bus.hi !== 32'hA5A5_0001) $display("FAIL mt_both_hi: got %h want a5a50001", bus.hi); else passed++;
    checks++; if (bus.lo !== 32'hA5A5_0001) $display("FAIL mt_both_lo: got %h want a5a50001", bus.lo); else passed++;
    write_hl(1'b1, 1'b0, 32'h0000_BEEF);
    checks++; if (bus.hi !== 32'h0000_BEEF) $display("FAIL mthi_hi: got %h want 0000beef", bus.hi); else passed++;
    checks++; if (bus.lo !== 32'hA5A5_0001) $display("FAIL mthi_lo: got %h want a5a50001", bus.lo); else passed++;
  endtask

  task automatic test_mul_max();
    int lat;
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
    checks++; if (lat !== 33) $display("FAIL mulmax_latency: got %0d want 33", lat); else passed++;
    checks++; if (bus.hi !== 32'hFFFF_FFFE) $display("FAIL mulmax_hi: got %h want fffffffe", bus.hi); else passed++;
    checks++; if (bus.lo !== 32'h0000_0001) $display("FAIL mulmax_lo: got %h want 00000001", bus.lo); else passed++;
    @(posedge clk); #1;
    checks++; if (bus.done !== 1'b0) $display("FAIL done_pulse_width: got %b want 0", bus.done); else passed++;
    checks++; if (bus.busy !== 1'b0) $display("FAIL busy_after_done: got %b want 0", bus.busy); else passed++;
  endtask

  task automatic test_divu();
    int lat;
    run_op(2'b10, 32'd100, 32'd7, lat);
    checks++; if (lat !== 33) $display("FAIL divu_latency: got %0d want 33", lat); else passed++;
    checks++; if (bus.lo !== 32'd14) $display("FAIL divu_lo: got %h want 0000000e", bus.lo); else passed++;
    checks++; if (bus.hi !== 32'd2) $display("FAIL divu_hi: got %h want 00000002", bus.hi); else passed++;
    run_op(2'b10, 32'd5, 32'd0, lat);
    checks++; if (bus.lo !== 32'hFFFF_FFFF) $display("FAIL div0_lo: got %h want ffffffff", bus.lo); else passed++;
    checks++; if (bus.hi !== 32'd5) $display("FAIL div0_hi: got %h want 00000005", bus.hi); else passed++;
  endtask

  task automatic test_signed_ops();
    int lat;
    logic [31:0] eh, el;
`ifdef MULDIV_SIGNED_EN
    eh = 32'hFFFF_FFFF; el = 32'hFFFF_FFF1;
`else
    eh = 32'h0000_0004; el = 32'hFFFF_FFF1;
`endif
    run_op(2'b01, 32'hFFFF_FFFD, 32'd5, lat);
    checks++; if (lat !== 33) $display("FAIL mult_latency: got %0d want 33", lat); else passed++;
    checks++; if (bus.hi !== eh) $display("FAIL mult_hi: got %h want %h", bus.hi, eh); else passed++;
    checks++; if (bus.lo !== el) $display("FAIL mult_lo: got %h want %h", bus.lo, el); else passed++;
`ifdef MULDIV_SIGNED_EN
    eh = 32'hFFFF_FFFF; el = 32'hFFFF_FFFD;
`else
    eh = 32'h0000_0001; el = 32'h7FFF_FFFC;
`endif
    run_op(2'b11, 32'hFFFF_FFF9, 32'd2, lat);
    checks++; if (bus.lo !== el) $display("FAIL div_lo: got %h want %h", bus.lo, el); else passed++;
    checks++; if (bus.hi !== eh) $display("FAIL div_hi: got %h want %h", bus.hi, eh); else passed++;
    {eh, el} = model(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, lat);
    checks++; if ({bus.hi, bus.lo} !== {eh, el}) $display("FAIL div_ovf: got %h_%h want %h_%h", bus.hi, bus.lo, eh, el); else passed++;
    {eh, el} = model(2'b11, 32'hFFFF_FFF0, 32'd0);
    run_op(2'b11, 32'hFFFF_FFF0, 32'd0, lat);
    checks++; if ({bus.hi, bus.lo} !== {eh, el}) $display("FAIL sdiv0: got %h_%h want %h_%h", bus.hi, bus.lo, eh, el); else passed++;
  endtask

  task automatic test_random();
    int lat;
    logic [1:0] op;
    logic [31:0] a, b;
    logic [63:0] exp;
    for (int i = 0; i < 24; i++) begin
      op = 2'($urandom_range(0, 3));
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
      if ($urandom_range(0, 4) == 0) a = 32'($urandom_range(0, 200));
      exp = model(op, a, b);
      run_op(op, a, b, lat);
      checks++; if (lat !== 33) $display("FAIL rand_latency[%0d]: got %0d want 33", i, lat); else passed++;
      checks++;
      if ({bus.hi, bus.lo} !== exp)
        $display("FAIL rand_result[%0d] op=%0d a=%h b=%h: got %h_%h want %h", i, op, a, b, bus.hi, bus.lo, exp);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    int lat1, lat2;
    logic [63:0] e1, e2;
    e1 = model(2'b00, 32'h1234_5678, 32'h9ABC_DEF0);
    e2 = model(2'b10, 32'hDEAD_BEEF, 32'h0000_1001);
    run_op(2'b00, 32'h1234_5678, 32'h9ABC_DEF0, lat1);
    checks++; if ({bus.hi, bus.lo} !== e1) $display("FAIL b2b_first: got %h_%h want %h", bus.hi, bus.lo, e1); else passed++;
    run_op(2'b10, 32'hDEAD_BEEF, 32'h0000_1001, lat2);
    checks++; if (lat2 !== 33) $display("FAIL b2b_latency: got %0d want 33", lat2); else passed++;
    checks++; if ({bus.hi, bus.lo} !== e2) $display("FAIL b2b_second: got %h_%h want %h", bus.hi, bus.lo, e2); else passed++;
  endtask

  task automatic test_cancel();
    int seen;
    write_hl(1'b1, 1'b0, 32'h0000_1234);
    write_hl(1'b0, 1'b1, 32'h0000_5678);
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b00; bus.src_a = 32'hFFFF_FFFF; bus.src_b = 32'hFFFF_FFFF;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1 bus.cancel = 1'b1;
    @(posedge clk); #1 bus.cancel = 1'b0;
    checks++; if (bus.busy !== 1'b0) $display("FAIL cancel_busy: got %b want 0", bus.busy); else passed++;
    checks++; if (bus.hi !== 32'h0000_1234) $display("FAIL cancel_hi: got %h want 00001234", bus.hi); else passed++;
    checks++; if (bus.lo !== 32'h0000_5678) $display("FAIL cancel_lo: got %h want 00005678", bus.lo); else passed++;
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (bus.done) seen++; end
    checks++; if (seen !== 0) $display("FAIL cancel_no_done: got %0d pulses want 0", seen); else passed++;
    checks++; if (bus.hi !== 32'h0000_1234) $display("FAIL cancel_hi_later: got %h want 00001234", bus.hi); else passed++;
  endtask

  task automatic test_busy_ignore();
    int lat;
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b10; bus.src_a = 32'd1000; bus.src_b = 32'd3;
    @(posedge clk); #1 bus.start = 1'b0;
    lat = 0;
    while (lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 3) begin
        bus.start = 1'b1; bus.op = 2'b00; bus.src_a = 32'd77; bus.src_b = 32'd11;
        bus.wr_hi = 1'b1; bus.wdata = 32'hDEAD_0000;
      end
      if (lat == 5) begin bus.start = 1'b0; bus.wr_hi = 1'b0; end
      if (bus.done) break;
    end
    checks++; if (lat !== 33) $display("FAIL busy_latency: got %0d want 33", lat); else passed++;
    checks++; if (bus.lo !== 32'd333) $display("FAIL busy_lo: got %h want 0000014d", bus.lo); else passed++;
    checks++; if (bus.hi !== 32'd1) $display("FAIL busy_hi: got %h want 00000001", bus.hi); else passed++;
  endtask

  task automatic test_start_wr_same();
    int lat;
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b10; bus.src_a = 32'd50; bus.src_b = 32'd5;
    bus.wr_lo = 1'b1; bus.wdata = 32'h0000_BEEF;
    @(posedge clk); #1 bus.start = 1'b0; bus.wr_lo = 1'b0;
    lat = 0;
    while (lat < 100) begin @(posedge clk); #1; lat++; if (bus.done) break; end
    checks++; if (lat !== 33) $display("FAIL startwr_latency: got %0d want 33", lat); else passed++;
    checks++; if (bus.lo !== 32'd10) $display("FAIL startwr_lo: got %h want 0000000a", bus.lo); else passed++;
    checks++; if (bus.hi !== 32'd0) $display("FAIL startwr_hi: got %h want 00000000", bus.hi); else passed++;
  endtask

  task automatic test_reset_mid_op();
    int seen;
    write_hl(1'b1, 1'b1, 32'h0F0F_0F0F);
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b00; bus.src_a = 32'd12345; bus.src_b = 32'd678;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    checks++; if (bus.hi !== 32'd0) $display("FAIL rstmid_hi: got %h want 0", bus.hi); else passed++;
    checks++; if (bus.lo !== 32'd0) $display("FAIL rstmid_lo: got %h want 0", bus.lo); else passed++;
    checks++; if (bus.busy !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", bus.busy); else passed++;
    checks++; if (bus.done !== 1'b0) $display("FAIL rstmid_done: got %b want 0", bus.done); else passed++;
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (bus.done) seen++; end
    checks++; if (seen !== 0) $display("FAIL rstmid_no_done: got %0d pulses want 0", seen); else passed++;
  endtask

  initial begin
    bus.start = 1'b0; bus.op = 2'b00; bus.src_a = '0; bus.src_b = '0;
    bus.cancel = 1'b0; bus.wr_hi = 1'b0; bus.wr_lo = 1'b0; bus.wdata = '0;
    test_reset();
    test_mthi_mtlo();
    test_mul_max();
    test_divu();
    test_signed_ops();
    test_random();
    test_back_to_back();
    test_cancel();
    test_busy_ignore();
    test_start_wr_same();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
